// File: rtl/microondas_potencia.sv
// microondas_potencia: keypad-programmed microwave controller with BCD countdown,
// per-second tick prescaler and power-level duty window on the magnetron.
module microondas_potencia #(
  parameter int CLK_HZ       = 100,
  parameter int MIN_DIGITOS  = 1,
  parameter int NIVEIS_POT   = 10,
  parameter int TEMPO_RAPIDO = 30
) (
  input  logic                     clk100Hz,
  input  logic                     clr,
  input  logic [9:0]               teclado,
  input  logic                     sel_potencia,
  input  logic                     startn,
  input  logic                     stopn,
  input  logic                     porta_fechada,
  output logic [3:0]               seg_unidades,
  output logic [3:0]               seg_dezenas,
  output logic [4*MIN_DIGITOS-1:0] minutos,
  output logic [3:0]               potencia,
  output logic [1:0]               estado,
  output logic                     ligar,
  output logic                     fim
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam int MW = 4 * MIN_DIGITOS;
  typedef enum logic [1:0] {IDLE, COZINHANDO, PAUSADO, FIM} estado_t;
  estado_t estado_q;
  logic [9:0] tec_q, tec_prev_q;
  logic sel_q, start_q, start_prev_q, stop_q, stop_prev_q, porta_q, fim_q;
  logic [3:0] uni_q, dez_q, pot_q, duty_q;
  logic [MW-1:0] min_q;
  logic [PW-1:0] pre_q;
  logic [3:0] uni_d, dez_d, key_d;
  logic [MW-1:0] min_d;
  logic zero_d, brw, key_ev, start_ev, stop_ev, tempo_zero, tick, pot_ok;
  assign key_ev     = (tec_prev_q == '0) && $onehot(tec_q);
  assign start_ev   = start_prev_q & ~start_q;
  assign stop_ev    = stop_prev_q & ~stop_q;
  assign tempo_zero = (min_q == '0) && (dez_q == 4'd0) && (uni_q == 4'd0);
  assign tick       = pre_q == PW'(CLK_HZ - 1);
  assign pot_ok     = key_d <= 4'(NIVEIS_POT);
  always_comb begin
    key_d = 4'd0;
    for (int i = 0; i < 10; i++)
      if (tec_q[i]) key_d = 4'(i);
  end
  // One-second BCD countdown; minutes borrow digit by digit from the right.
  always_comb begin
    uni_d = uni_q - 4'd1;
    dez_d = dez_q;
    min_d = min_q;
    brw   = 1'b1;
    if (uni_q == 4'd0) begin
      uni_d = 4'd9;
      dez_d = dez_q - 4'd1;
      if (dez_q == 4'd0) begin
        dez_d = 4'd5;
        for (int i = 0; i < MIN_DIGITOS; i++)
          if (brw) begin
            min_d[4*i+:4] = min_q[4*i+:4] == 4'd0 ? 4'd9 : min_q[4*i+:4] - 4'd1;
            brw = min_q[4*i+:4] == 4'd0;
          end
      end
    end
    zero_d = (min_d == '0) && (dez_d == 4'd0) && (uni_d == 4'd0);
  end
  always_ff @(posedge clk100Hz) begin
    if (clr) begin
      tec_q        <= '0;
      tec_prev_q   <= '0;
      sel_q        <= 1'b0;
      start_q      <= 1'b1;
      start_prev_q <= 1'b1;
      stop_q       <= 1'b1;
      stop_prev_q  <= 1'b1;
      porta_q      <= 1'b0;
      estado_q     <= IDLE;
      uni_q        <= 4'd0;
      dez_q        <= 4'd0;
      min_q        <= '0;
      pot_q        <= 4'(NIVEIS_POT);
      pre_q        <= '0;
      duty_q       <= 4'd0;
      fim_q        <= 1'b0;
    end else begin
      tec_q        <= teclado;
      tec_prev_q   <= tec_q;
      sel_q        <= sel_potencia;
      start_q      <= startn;
      start_prev_q <= start_q;
      stop_q       <= stopn;
      stop_prev_q  <= stop_q;
      porta_q      <= porta_fechada;
      fim_q        <= 1'b0;
      case (estado_q)
        IDLE:
          if (stop_ev) begin
            uni_q <= 4'd0;
            dez_q <= 4'd0;
            min_q <= '0;
          end else if (start_ev && porta_q) begin
            estado_q <= COZINHANDO;
            pre_q    <= '0;
            duty_q   <= 4'd0;
            if (tempo_zero) begin
              uni_q <= 4'(TEMPO_RAPIDO % 10);
              dez_q <= 4'(TEMPO_RAPIDO / 10);
            end
          end else if (key_ev && sel_q) begin
            if (key_d == 4'd0) pot_q <= 4'(NIVEIS_POT);
            else if (pot_ok) pot_q <= key_d;
          end else if (key_ev) begin
            min_q <= MW'({min_q, dez_q});
            dez_q <= uni_q;
            uni_q <= key_d;
          end
        COZINHANDO:
          if (stop_ev || !porta_q) estado_q <= PAUSADO;
          else if (tick) begin
            pre_q  <= '0;
            duty_q <= duty_q == 4'(NIVEIS_POT - 1) ? 4'd0 : duty_q + 4'd1;
            uni_q  <= uni_d;
            dez_q  <= dez_d;
            min_q  <= min_d;
            if (zero_d) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
            end
          end else pre_q <= pre_q + PW'(1);
        PAUSADO:
          if (stop_ev) begin
            estado_q <= IDLE;
            uni_q    <= 4'd0;
            dez_q    <= 4'd0;
            min_q    <= '0;
          end else if (start_ev && porta_q) estado_q <= COZINHANDO;
        FIM:
          if (key_ev || stop_ev || !porta_q) estado_q <= IDLE;
      endcase
    end
  end
  assign seg_unidades = uni_q;
  assign seg_dezenas  = dez_q;
  assign minutos      = min_q;
  assign potencia     = pot_q;
  assign estado       = estado_q;
  assign fim          = fim_q;
  // Raw door input so opening the door cuts the magnetron without register delay.
  assign ligar        = (estado_q == COZINHANDO) & porta_fechada & (duty_q < pot_q);
endmodule

// File: tb/tb_microondas_potencia.sv
// tb_microondas_potencia: directed and randomized checks of microondas_potencia
// against a per-cycle behavioural model of the controller rules.
module tb_microondas_potencia;
  localparam int CLK_HZ = 10;
  localparam int MD     = 2;
  localparam int NP     = 5;
  localparam int TR     = 30;
  localparam int MW     = 4 * MD;

  logic          clk = 1'b0;
  logic          clr, sel_potencia, startn, stopn, porta_fechada;
  logic [9:0]    teclado;
  logic [3:0]    seg_unidades, seg_dezenas, potencia;
  logic [MW-1:0] minutos;
  logic [1:0]    estado;
  logic          ligar, fim;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  microondas_potencia #(.CLK_HZ(CLK_HZ), .MIN_DIGITOS(MD), .NIVEIS_POT(NP), .TEMPO_RAPIDO(TR)) dut (
    .clk100Hz(clk), .clr(clr), .teclado(teclado), .sel_potencia(sel_potencia),
    .startn(startn), .stopn(stopn), .porta_fechada(porta_fechada),
    .seg_unidades(seg_unidades), .seg_dezenas(seg_dezenas), .minutos(minutos),
    .potencia(potencia), .estado(estado), .ligar(ligar), .fim(fim)
  );

  always #5 clk = ~clk;

  // Model state: time kept as integer minutes plus tens/units seconds digits.
  int m_st = 0, m_min = 0, m_ten = 0, m_uni = 0, m_pot = NP, m_pre = 0, m_duty = 0;
  bit m_fim = 0;
  logic [9:0] r_tec = '0, p_tec = '0;
  bit r_sel = 0, r_st = 1, p_st = 1, r_sp = 1, p_sp = 1, r_door = 0;

  function automatic logic [MW-1:0] bcd(int v);
    logic [MW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < MD; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step();
    bit kev, sev, pev, zero;
    int kd;
    if (clr) begin
      m_st = 0; m_min = 0; m_ten = 0; m_uni = 0; m_pot = NP; m_pre = 0; m_duty = 0; m_fim = 0;
      r_tec = '0; p_tec = '0; r_sel = 0; r_st = 1; p_st = 1; r_sp = 1; p_sp = 1; r_door = 0;
      return;
    end
    kev = (p_tec == 0) && ($countones(r_tec) == 1);
    kd = 0;
    for (int i = 0; i < 10; i++) if (r_tec[i]) kd = i;
    sev = p_st && !r_st;
    pev = p_sp && !r_sp;
    zero = (m_min == 0) && (m_ten == 0) && (m_uni == 0);
    m_fim = 0;
    if (m_st == 0) begin
      if (pev) begin m_min = 0; m_ten = 0; m_uni = 0; end
      else if (sev && r_door) begin
        if (zero) begin m_min = TR / 60; m_ten = (TR % 60) / 10; m_uni = TR % 10; end
        m_st = 1; m_pre = 0; m_duty = 0;
      end else if (kev && r_sel) begin
        if (kd == 0) m_pot = NP;
        else if (kd <= NP) m_pot = kd;
      end else if (kev) begin
        m_min = (m_min * 10 + m_ten) % (10 ** MD);
        m_ten = m_uni;
        m_uni = kd;
      end
    end else if (m_st == 1) begin
      if (pev || !r_door) m_st = 2;
      else if (m_pre == CLK_HZ - 1) begin
        m_pre = 0;
        m_duty = (m_duty + 1) % NP;
        if (m_uni > 0) m_uni--;
        else if (m_ten > 0) begin m_ten--; m_uni = 9; end
        else begin m_min--; m_ten = 5; m_uni = 9; end
        if (m_min == 0 && m_ten == 0 && m_uni == 0) begin m_st = 3; m_fim = 1; end
      end else m_pre++;
    end else if (m_st == 2) begin
      if (pev) begin m_st = 0; m_min = 0; m_ten = 0; m_uni = 0; end
      else if (sev && r_door) m_st = 1;
    end else if (kev || pev || !r_door) m_st = 0;
    p_tec = r_tec; r_tec = teclado; r_sel = sel_potencia;
    p_st = r_st; r_st = startn; p_sp = r_sp; r_sp = stopn; r_door = porta_fechada;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    logic exp_l;
    logic [MW-1:0] exp_m;
    if (chk_en) begin
      exp_l = (m_st == 1) && porta_fechada && (m_duty < m_pot);
      exp_m = bcd(m_min);
      vectors++;
      if ({seg_unidades, seg_dezenas, minutos, potencia, estado, ligar, fim} !==
          {4'(m_uni), 4'(m_ten), exp_m, 4'(m_pot), 2'(m_st), exp_l, m_fim}) begin
        miscompares++;
        $display("FAIL model t=%0t: dut u=%h d=%h m=%h p=%0d e=%0d l=%b f=%b, model u=%0d d=%0d m=%h p=%0d e=%0d l=%b f=%b",
                 $time, seg_unidades, seg_dezenas, minutos, potencia, estado, ligar, fim,
                 m_uni, m_ten, exp_m, m_pot, m_st, exp_l, m_fim);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_time(string nm, logic [MW-1:0] m, logic [3:0] d, logic [3:0] u);
    chk({nm, "_min"}, minutos, m);
    chk({nm, "_dez"}, seg_dezenas, d);
    chk({nm, "_uni"}, seg_unidades, u);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(int d, bit s);
    sel_potencia = s;
    teclado = 10'(1) << d;
    step(2);
    teclado = '0;
    step(2);
  endtask

  task automatic press_start();
    startn = 1'b0;
    step(2);
    startn = 1'b1;
    step(1);
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    step(2);
    stopn = 1'b1;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; teclado = '0; sel_potencia = 1'b0; startn = 1'b1; stopn = 1'b1; porta_fechada = 1'b1;
    step(2);
    chk_en = 1'b1;
    clr = 1'b0;
    step(1);
    chk("rst_estado", estado, 0);
    chk("rst_pot", potencia, NP);
    chk_time("rst", 0, 0, 0);
    chk("rst_ligar", ligar, 0);
    chk("rst_fim", fim, 0);
    // Keys 1,3,0 then cook at full power.
    press_key(1, 0); press_key(3, 0); press_key(0, 0);
    chk_time("entry", 'h01, 3, 0);
    press_start();
    chk("cook_estado", estado, 1);
    step(CLK_HZ - 2);
    chk_time("pre_tick", 'h01, 3, 0);
    step(1);
    chk_time("first_tick", 'h01, 2, 9);
    chk("full_pot_ligar", ligar, 1);
    press_stop();
    chk("pause_estado", estado, 2);
    chk_time("pause_hold", 'h01, 2, 9);
    press_stop();
    chk("stop_idle", estado, 0);
    chk_time("stop_clear", 0, 0, 0);
    // 0:05 at power 3: on for seconds 0-2, off for 3-4, then FIM.
    press_key(3, 1);
    chk("pot3", potencia, 3);
    press_key(0, 0); press_key(5, 0);
    press_start();
    step(2 * CLK_HZ - 1);
    chk_time("duty_s2", 0, 0, 3);
    chk("duty_on", ligar, 1);
    step(CLK_HZ);
    chk_time("duty_s3", 0, 0, 2);
    chk("duty_off", ligar, 0);
    step(2 * CLK_HZ);
    chk("fim_estado", estado, 3);
    chk("fim_pulse", fim, 1);
    chk("fim_ligar", ligar, 0);
    step(1);
    chk("fim_once", fim, 0);
    chk("fim_stay", estado, 3);
    press_key(1, 0);
    chk("fim_exit", estado, 0);
    chk_time("fim_nokey", 0, 0, 0);
    // Door interlock mid-second, then resume from the held prescaler.
    press_key(0, 1);
    chk("pot_key0", potencia, NP);
    press_key(4, 0); press_key(0, 0);
    press_start();
    step(CLK_HZ + 2);
    chk_time("door_pre", 0, 3, 9);
    porta_fechada = 1'b0;
    #1;
    chk("door_cut", ligar, 0);
    step(2);
    chk("door_pause", estado, 2);
    step(5);
    chk_time("door_hold", 0, 3, 9);
    porta_fechada = 1'b1;
    step(1);
    press_start();
    chk("resume", estado, 1);
    step(4);
    chk_time("resume_hold", 0, 3, 9);
    step(1);
    chk_time("resume_tick", 0, 3, 8);
    // Start and stop together while cooking: stop wins.
    startn = 1'b0; stopn = 1'b0;
    step(2);
    chk("both_pause", estado, 2);
    startn = 1'b1; stopn = 1'b1;
    step(1);
    press_stop();
    chk("both_idle", estado, 0);
    chk_time("both_clear", 0, 0, 0);
    // Quick start, door-open start ignored.
    press_key(2, 1);
    porta_fechada = 1'b0;
    press_start();
    chk("open_start", estado, 0);
    chk_time("open_start", 0, 0, 0);
    porta_fechada = 1'b1;
    step(1);
    press_start();
    chk("quick_estado", estado, 1);
    chk_time("quick", 0, 3, 0);
    // Clear while cooking.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_estado", estado, 0);
    chk("clr_ligar", ligar, 0);
    chk("clr_pot", potencia, NP);
    chk_time("clr", 0, 0, 0);
    // Illegal, held and out-of-range keys.
    sel_potencia = 1'b1; teclado = 10'b0000000011; step(2); teclado = '0; step(2);
    chk("multi_pot", potencia, NP);
    sel_potencia = 1'b0; teclado = 10'b0000000110; step(2); teclado = '0; step(2);
    chk_time("multi_time", 0, 0, 0);
    press_key(2, 1);
    press_key(7, 1);
    chk("pot_range", potencia, 2);
    press_key(0, 1);
    chk("pot_zero", potencia, NP);
    sel_potencia = 1'b0; teclado = 10'(1) << 2; step(10); teclado = '0; step(2);
    chk_time("held", 0, 0, 2);
    press_key(1, 0); press_key(2, 0); press_key(3, 0); press_key(4, 0); press_key(5, 0);
    chk_time("discard", 'h23, 4, 5);
    // Minute borrow across digits and literal tens above 5.
    press_stop();
    press_key(1, 0); press_key(0, 0); press_key(0, 0); press_key(0, 0);
    press_start();
    step(CLK_HZ - 1);
    chk_time("borrow", 'h09, 5, 9);
    press_stop(); press_stop();
    press_key(7, 0); press_key(0, 0);
    press_start();
    step(CLK_HZ - 1);
    chk_time("tens7", 0, 6, 9);
    press_stop(); press_stop();
    // Randomized phase, checked every cycle by the model.
    repeat (4000) begin
      int r;
      r = $urandom_range(0, 999);
      if (teclado != '0) begin
        if ($urandom_range(0, 3) == 0) teclado = '0;
      end else if (r < 25) teclado = 10'(1) << $urandom_range(0, 9);
      else if (r < 28) teclado = 10'($urandom);
      startn = $urandom_range(0, 99) >= 4;
      stopn = $urandom_range(0, 999) >= 6;
      if ($urandom_range(0, 199) == 0) porta_fechada = ~porta_fechada;
      if ($urandom_range(0, 19) == 0) sel_potencia = ~sel_potencia;
      clr = $urandom_range(0, 1999) == 0;
      step(1);
    end
    clr = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/microondas_potencia.md
# microondas_potencia

Parametrised second-generation microwave controller. Accepts keypad digits for a BCD cook time and a power level, and counts the time down once per second from an internal prescaler on the system clock. Drives the magnetron with a per-second duty cycle set by the power level, and handles start, stop, pause and door interlock through an explicit state machine. It replaces the fixed encoder/timer/magnetron chain at the top of the microwave design and exposes BCD digits to the existing seven-segment decoder stage.

## Interface
- CLK_HZ, 100: clock cycles per second; sets the 1 s tick period.
- MIN_DIGITOS, 1: number of BCD minute digits (1 or 2).
- NIVEIS_POT, 10: number of power levels, legal range 2..10. It is also the duty window length in seconds.
- TEMPO_RAPIDO, 30: seconds loaded by quick start (≤59).

Ports:
- clk100Hz  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- teclado  in  10  one-hot keypad, bit k = digit k; 0 = no key.
- sel_potencia  in  1  1 = digit keys set power, 0 = digit keys set time.
- startn  in  1  start button, active-low.
- stopn  in  1  stop/cancel button, active-low.
- porta_fechada  in  1  1 = door closed.
- seg_unidades  out  4  BCD seconds units.
- seg_dezenas  out  4  BCD seconds tens.
- minutos  out  4*MIN_DIGITOS  BCD minutes, least-significant digit in bits [3:0].
- potencia  out  4  current power level, 1..NIVEIS_POT.
- estado  out  2  0 IDLE, 1 COZINHANDO, 2 PAUSADO, 3 FIM.
- ligar  out  1  magnetron enable.
- fim  out  1  one-cycle pulse on completion.

## Operation
- Reset values: all digits 0, potencia = NIVEIS_POT, estado = IDLE, fim = 0, prescaler = 0, duty counter = 0. ligar = 0 follows from estado = IDLE.
- Inputs are registered once. An event is a registered edge: a key is a 0→nonzero transition of teclado with exactly one bit set; startn and stopn act on their 1→0 edge. A key with multiple bits set is ignored. A held key or button produces exactly one event.
- Keys act only in IDLE:
  - sel_potencia = 0: shift-in from the right. New digit goes to units, units to tens, tens to minutes[3:0], and so on. The top digit is discarded.
  - sel_potencia = 1: key d sets potencia = d for 1 ≤ d ≤ NIVEIS_POT. Key 0 sets NIVEIS_POT. d > NIVEIS_POT is ignored.
- Entered tens above 5 are kept literally. Countdown decrements them normally.
- State transitions; when stop and another event occur in the same cycle, stop wins:
  - IDLE, start, door closed, time ≠ 0 → COZINHANDO. Prescaler and duty counter are cleared.
  - IDLE, start, door closed, time = 0 → load TEMPO_RAPIDO, then COZINHANDO as above.
  - IDLE, start, door open → ignored.
  - IDLE, stop → clear all time digits. potencia is unchanged.
  - COZINHANDO, stop or door open → PAUSADO. Time, prescaler and duty counter are held.
  - PAUSADO, start, door closed → COZINHANDO. Prescaler and duty counter resume from their held values.
  - PAUSADO, stop → IDLE with time cleared.
  - COZINHANDO, tick that decrements time to 0:00 → FIM on the same edge.
  - FIM, any key, stop or door open → IDLE. Time stays 0 and the key is not entered.
- Countdown:
  - units > 0: decrement units.
  - Otherwise, tens > 0: tens −1, units = 9.
  - Otherwise, minutes ≠ 0: minutes −1 (BCD, with borrow across minute digits), tens = 5, units = 9.
- Duty counter runs 0..NIVEIS_POT−1. It advances on each tick and wraps.
- ligar = (estado == COZINHANDO) & porta_fechada & (duty counter < potencia). The porta_fechada term is the raw input, not the registered copy, so door opening cuts the magnetron combinationally.

## Timing
- Prescaler counts only in COZINHANDO. A tick occurs on the cycle it equals CLK_HZ−1; the prescaler then wraps to 0.
- First decrement happens CLK_HZ cycles after entry to COZINHANDO from IDLE.
- Event latency: an input edge at cycle n changes state and outputs after edge n+2 (one input register plus one state update).
- fim is high for exactly the first cycle spent in FIM.
- Clear while cooking returns to reset values on the next edge. ligar falls in the same cycle.

## Test plan
- Reset, then keys 1,3,0 in time mode → minutos=1, dezenas=3, unidades=0. Start with door closed → estado=1, first decrement to 1:29 after 100 cycles, ligar=1 continuously at potencia 10.
- Enter 0:05, potencia key 3, start → ligar high for seconds 0–2 and low for seconds 3–9 of each 10 s window. At 0:00: estado=3, fim one cycle, ligar=0.
- Cooking 0:40, door opened mid-second → ligar=0 the same cycle, estado=2, time held. Door closed, start → resumes at the same prescaler count; total elapsed ticks unchanged.
- IDLE with time 0, start → loads 0:30 and cooks. Start with door open → no change.
- startn and stopn fall in the same cycle while COZINHANDO → PAUSADO. Stop again → IDLE with digits 0.
- Key with teclado=10'b0000000011, a held key, and key 7 with sel_potencia=1 while NIVEIS_POT=5 → all ignored. Key 0 with sel_potencia=1 → potencia=5.
